// File: rtl/tree_pkg.sv
// Shared definitions for operator-tree nodes: state encodings and default sizing.
package tree_pkg;

  localparam int DEF_W   = 16;
  localparam int DEF_TMO = 255;
  localparam int WDOG_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ZERO    = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } nodeState_t;

  typedef enum logic [1:0] {
    SUCC_IDLE = 2'd0,
    SUCC_BUSY = 2'd1,
    SUCC_CALC = 2'd2
  } succState_t;

endpackage

// File: rtl/node_edge_det.sv
// Rising-edge detector for a node's start input; the history bit updates every cycle,
// so a level held high never produces a second edge.
module node_edge_det (
  input  logic CLK,
  input  logic RST,
  input  logic i_sig,
  output logic o_rise
);

  logic r_old;

  always_ff @(posedge CLK) begin
    if (RST) r_old <= 1'b0;
    else     r_old <= i_sig;
  end

  assign o_rise = i_sig & ~r_old;

endmodule

// File: rtl/node_succ.sv
// Successor node: RES = IN + 1, using the common ST/RD/RES tree-node handshake.
// RD stays low for two cycles so each request costs a fixed four-cycle round trip.
module node_succ
  import tree_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ST,
  input  logic [W-1:0] IN,
  output logic         RD,
  output logic [W-1:0] RES
);

  succState_t   r_state, w_stateNext;
  logic [W-1:0] r_arg, w_argNext;
  logic [W-1:0] r_res, w_resNext;
  logic         r_rd, w_rdNext;
  logic         w_start;

  node_edge_det u_stEdge (
    .CLK    (CLK),
    .RST    (RST),
    .i_sig  (ST),
    .o_rise (w_start)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= SUCC_IDLE;
      r_arg   <= '0;
      r_res   <= '0;
      r_rd    <= 1'b1;
    end else begin
      r_state <= w_stateNext;
      r_arg   <= w_argNext;
      r_res   <= w_resNext;
      r_rd    <= w_rdNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      SUCC_IDLE: if (w_start) w_stateNext = SUCC_BUSY;
      SUCC_BUSY: w_stateNext = SUCC_CALC;
      SUCC_CALC: w_stateNext = SUCC_IDLE;
      default:   w_stateNext = SUCC_IDLE;
    endcase
  end

  always_comb begin
    w_argNext = r_arg;
    w_resNext = r_res;
    w_rdNext  = r_rd;
    case (r_state)
      SUCC_IDLE: begin
        if (w_start) begin
          w_argNext = IN;
          w_rdNext  = 1'b0;
        end
      end
      SUCC_CALC: begin
        w_resNext = r_arg + W'(1);
        w_rdNext  = 1'b1;
      end
      default: ;
    endcase
  end

  assign RD  = r_rd;
  assign RES = r_res;

endmodule

// File: rtl/node_iter_drive.sv
// Iteration driver: applies its unary child CNT times, feeding each child result back
// as the next argument, so RES = f^CNT(IN). A per-iteration watchdog aborts a stuck child.
module node_iter_drive
  import tree_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int TMO = DEF_TMO
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ST,
  input  logic [W-1:0] IN,
  input  logic [W-1:0] CNT,
  output logic         RD,
  output logic [W-1:0] RES,
  output logic         ERR,
  output logic         C_ST,
  output logic [W-1:0] C_IN,
  input  logic         C_RD,
  input  logic [W-1:0] C_RES
);

  localparam logic [WDOG_W-1:0] TMO_LAST = WDOG_W'(TMO - 1);

  nodeState_t        r_state, w_stateNext;
  logic [W-1:0]      r_acc, w_accNext;
  logic [W-1:0]      r_rem, w_remNext;
  logic [WDOG_W-1:0] r_wdog, w_wdogNext;
  logic              r_rd, w_rdNext;
  logic [W-1:0]      r_res, w_resNext;
  logic              r_err, w_errNext;
  logic              r_cSt, w_cStNext;
  logic [W-1:0]      r_cIn, w_cInNext;
  logic              w_start;
  logic              w_waiting;
  logic              w_timeout;
  logic              w_remOne;

  node_edge_det u_stEdge (
    .CLK    (CLK),
    .RST    (RST),
    .i_sig  (ST),
    .o_rise (w_start)
  );

  assign w_waiting = (r_state == WAIT_LO) || (r_state == WAIT_HI);
  assign w_timeout = w_waiting && (r_wdog == TMO_LAST);
  assign w_remOne  = (r_rem == W'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_rem   <= '0;
      r_wdog  <= '0;
      r_rd    <= 1'b1;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_cSt   <= 1'b0;
      r_cIn   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_acc   <= w_accNext;
      r_rem   <= w_remNext;
      r_wdog  <= w_wdogNext;
      r_rd    <= w_rdNext;
      r_res   <= w_resNext;
      r_err   <= w_errNext;
      r_cSt   <= w_cStNext;
      r_cIn   <= w_cInNext;
    end
  end

  // Completion is only taken from WAIT_HI, so the child's idle RD=1 is never mistaken for a result.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_start) w_stateNext = (CNT == '0) ? ZERO : WAIT_LO;
      ZERO:    w_stateNext = IDLE;
      WAIT_LO: begin
        if (w_timeout)  w_stateNext = IDLE;
        else if (!C_RD) w_stateNext = WAIT_HI;
      end
      WAIT_HI: begin
        if (w_timeout) w_stateNext = IDLE;
        else if (C_RD) w_stateNext = w_remOne ? IDLE : WAIT_LO;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_accNext  = r_acc;
    w_remNext  = r_rem;
    w_wdogNext = r_wdog;
    w_rdNext   = r_rd;
    w_resNext  = r_res;
    w_errNext  = r_err;
    w_cStNext  = 1'b0;
    w_cInNext  = r_cIn;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_accNext = IN;
          w_remNext = CNT;
          w_errNext = 1'b0;
          w_rdNext  = 1'b0;
          if (CNT != '0) begin
            w_cInNext  = IN;
            w_cStNext  = 1'b1;
            w_wdogNext = '0;
          end
        end
      end
      ZERO: begin
        w_resNext = r_acc;
        w_rdNext  = 1'b1;
      end
      WAIT_LO, WAIT_HI: begin
        w_wdogNext = r_wdog + WDOG_W'(1);
        if (w_timeout) begin
          w_errNext = 1'b1;
          w_resNext = r_acc;
          w_rdNext  = 1'b1;
        end else if ((r_state == WAIT_HI) && C_RD) begin
          w_accNext = C_RES;
          w_remNext = r_rem - W'(1);
          if (w_remOne) begin
            w_resNext = C_RES;
            w_rdNext  = 1'b1;
          end else begin
            w_cInNext  = C_RES;
            w_cStNext  = 1'b1;
            w_wdogNext = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign RD   = r_rd;
  assign RES  = r_res;
  assign ERR  = r_err;
  assign C_ST = r_cSt;
  assign C_IN = r_cIn;

endmodule

// File: doc/node_iter_drive.md
Name: node_iter_drive

Overview:
- Iteration driver node for the operator tree.
- Sits directly upstream of a unary child node (typically the successor node, which computes RES = IN + 1) and drives its ST/IN handshake.
- Applies the child CNT times, feeding each child result back as the next child input, so it computes f^CNT(IN). With a successor child this yields IN + CNT mod 2^W.
- Presents the same ST/RD/RES handshake upstream as every other tree node.

Parameters:
- W, 16, data and count width.
- TMO, 255, watchdog limit in cycles per child iteration (1..65535).

Ports:
- CLK  in  1  clock. All logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ST  in  1  start. Rising edge (ST=1 with previous-cycle ST=0) launches an operation.
- IN  in  W  initial argument, sampled at the start edge.
- CNT  in  W  iteration count, sampled at the start edge.
- RD  out  1  ready. 0 while busy; 1 when idle or done.
- RES  out  W  result. Valid whenever RD=1 after a completed operation.
- ERR  out  1  watchdog timeout flag for the last operation.
- C_ST  out  1  start pulse to the child.
- C_IN  out  W  argument to the child.
- C_RD  in  1  child ready.
- C_RES  in  W  child result.

Behaviour:
- Reset values: RD=1, RES=0, ERR=0, C_ST=0, C_IN=0, state IDLE, STold=0. RST overrides everything, including mid-operation (return to IDLE); the child shares RST.
- Internal registers: acc[W], rem[W], wdog counter, STold.
- States: IDLE, ZERO, WAIT_LO, WAIT_HI.
- IDLE, on ST rising edge:
  - acc=IN, rem=CNT, ERR=0, RD=0.
  - If CNT=0: go to ZERO.
  - Otherwise: C_IN=IN, C_ST=1, wdog=0, go to WAIT_LO.
- ZERO: RES=acc, RD=1, go to IDLE. RD is low for exactly one cycle.
- WAIT_LO:
  - C_ST=0 (the pulse is exactly one cycle wide).
  - If C_RD=0 (child acknowledged), go to WAIT_HI.
- WAIT_HI, when C_RD=1:
  - acc=C_RES, rem=rem-1.
  - If rem becomes 0: RES=C_RES, RD=1, go to IDLE.
  - Otherwise: C_IN=C_RES, C_ST=1, wdog=0, go to WAIT_LO.
- Watchdog:
  - wdog increments every cycle in WAIT_LO or WAIT_HI.
  - On reaching TMO: ERR=1, RES=acc (last good value), RD=1, C_ST=0, go to IDLE.
  - ERR is held until the next start edge or RST.
- Timing with the successor child: 4 cycles per iteration. With the ST edge at edge 0, RD rises at edge 4*CNT.
- ST edges while RD=0 are ignored. STold updates every cycle regardless, so a held-high ST does not retrigger after completion.
- C_RD is required to fall before its rise is accepted. The child's idle RD=1 must never be mistaken for completion.
- Arithmetic: rem decrement never underflows, since the zero case is handled in IDLE. Value wrap-around is the child's responsibility (mod 2^W). CNT up to 2^W-1 is legal.

Decomposition:
- Shared package (tree_pkg): state encoding constants (IDLE/ZERO/WAIT_LO/WAIT_HI), default width 16, default TMO.
- Sub-module node_edge_det: the ST rising-edge detector (STold register), reusable by all tree nodes.
- The bench instantiates the real successor node as the child.

Test Plan:
- Reset, then IN=5, CNT=3, pulse ST -> RD low 12 cycles, then RES=8, ERR=0; C_ST shows exactly 3 single-cycle pulses with C_IN = 5, 6, 7.
- CNT=0, IN=0x1234 -> RD low exactly 1 cycle, then RES=0x1234; C_ST never asserted.
- IN=0xFFFE, CNT=4 -> RES=0x0002, ERR=0; wrap-around through the child.
- ST held high through completion, plus a second ST edge mid-operation -> exactly one operation; RES=IN+CNT; no retrigger.
- Child replaced by a stub whose C_RD never falls, TMO=10 -> ERR=1 and RD=1 after 10 cycles, RES=IN. The next start clears ERR.
- RST asserted during WAIT_HI of iteration 2 (of 5) -> next cycle RD=1, RES=0, C_ST=0, ERR=0. A fresh start with IN=1, CNT=2 -> RES=3.
